mouse_track_recorder: RTL and testbench

Builds the 52x52 handwriting bitmap for one Sudoku cell from the mouse cursor while the left button is held. Consecutive cursor samples are joined with a Bresenham line stepper, so fast mouse moves still leave continuous strokes. The block sits directly upstream of the mouse track display stage and of digit recognition, both of which consume `track` unchanged.

---
 rtl/mouse_track_recorder.sv | 225 ++++++++++++++++++++++
 tb/tb_mouse_track_recorder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_track_recorder.sv
// mouse_track_recorder: accumulates a BSIZE x BSIZE handwriting bitmap for one
// Sudoku cell from the mouse cursor. Consecutive cursor samples taken while
// the pen is down are joined by a Bresenham stepper that plots one point per
// cycle, so fast moves still leave continuous strokes.
module mouse_track_recorder #(
    parameter logic [9:0] H     = 10'd480,
    parameter logic [9:0] W     = 10'd640,
    parameter logic [5:0] BSIZE = 6'd52
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  draw_en,
    input  logic                                  clear,
    input  logic [9:0]                            mouse_x,
    input  logic [9:0]                            mouse_y,
    input  logic                                  mouse_left,
    input  logic [9:0]                            block_x_pos,
    input  logic [9:0]                            block_y_pos,
    output logic [32'(BSIZE)*32'(BSIZE)-1:0]      track,
    output logic                                  busy,
    output logic                                  stroke_done,
    output logic                                  track_empty
);

    localparam int B     = 32'(BSIZE);
    localparam int NBITS = B * B;
    localparam logic signed [10:0] BSIZE_S = {5'd0, BSIZE};

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DRAW = 1'b1;

    // A cell larger than the screen is a configuration error; nothing is built for it.
    generate
        if (B > 32'(W) || B > 32'(H)) begin : g_cell_larger_than_screen
        end
    endgenerate

    logic [NBITS-1:0]   track_reg, track_next;
    logic [0:0]         state_reg, state_next;
    logic [9:0]         prev_x_reg, prev_x_next, prev_y_reg, prev_y_next;
    logic               prev_valid_reg, prev_valid_next;
    logic signed [10:0] cur_x_reg, cur_x_next, cur_y_reg, cur_y_next;
    logic signed [10:0] end_x_reg, end_x_next, end_y_reg, end_y_next;
    logic signed [10:0] dx_reg, dx_next, dy_reg, dy_next, err_reg, err_next;
    logic signed [10:0] sx_reg, sx_next, sy_reg, sy_next;
    logic [9:0]         blk_x_reg, blk_x_next, blk_y_reg, blk_y_next;
    logic               stroke_done_reg, stroke_done_next;
    logic               track_empty_reg, track_empty_next;

    logic               pen;
    logic signed [10:0] cx, cy, px, py, diff_x, diff_y;
    logic signed [11:0] e2, dx12, dy12;
    logic               plot_en;
    logic signed [10:0] plot_x, plot_y, rel_x, rel_y;
    logic [9:0]         plot_bx, plot_by;
    logic               in_win;
    logic [11:0]        plot_idx;
    logic [B-1:0]       row_any;

    assign pen    = draw_en & mouse_left;
    assign cx     = {1'b0, mouse_x};
    assign cy     = {1'b0, mouse_y};
    assign px     = {1'b0, prev_x_reg};
    assign py     = {1'b0, prev_y_reg};
    assign diff_x = cx - px;
    assign diff_y = cy - py;
    assign e2     = {err_reg, 1'b0};
    assign dx12   = {dx_reg[10], dx_reg};
    assign dy12   = {dy_reg[10], dy_reg};

    // Control path: pen handling in IDLE, one Bresenham step per cycle in DRAW.
    always_comb begin
        state_next       = state_reg;
        prev_x_next      = prev_x_reg;
        prev_y_next      = prev_y_reg;
        prev_valid_next  = prev_valid_reg;
        cur_x_next       = cur_x_reg;
        cur_y_next       = cur_y_reg;
        end_x_next       = end_x_reg;
        end_y_next       = end_y_reg;
        dx_next          = dx_reg;
        dy_next          = dy_reg;
        err_next         = err_reg;
        sx_next          = sx_reg;
        sy_next          = sy_reg;
        blk_x_next       = blk_x_reg;
        blk_y_next       = blk_y_reg;
        stroke_done_next = 1'b0;
        plot_en          = 1'b0;
        plot_x           = cur_x_reg;
        plot_y           = cur_y_reg;
        plot_bx          = blk_x_reg;
        plot_by          = blk_y_reg;
        if (clear) begin
            state_next      = IDLE;
            prev_valid_next = 1'b0;
        end else if (state_reg == IDLE) begin
            if (!pen) begin
                prev_valid_next = 1'b0;
            end else if (!prev_valid_reg) begin
                plot_en          = 1'b1;
                plot_x           = cx;
                plot_y           = cy;
                plot_bx          = block_x_pos;
                plot_by          = block_y_pos;
                blk_x_next       = block_x_pos;
                blk_y_next       = block_y_pos;
                prev_x_next      = mouse_x;
                prev_y_next      = mouse_y;
                prev_valid_next  = 1'b1;
                stroke_done_next = 1'b1;
            end else if (mouse_x != prev_x_reg || mouse_y != prev_y_reg) begin
                cur_x_next = px;
                cur_y_next = py;
                end_x_next = cx;
                end_y_next = cy;
                dx_next    = (diff_x < 0) ? -diff_x : diff_x;
                dy_next    = (diff_y < 0) ? diff_y : -diff_y;
                err_next   = ((diff_x < 0) ? -diff_x : diff_x) + ((diff_y < 0) ? diff_y : -diff_y);
                sx_next    = (diff_x < 0) ? -11'sd1 : 11'sd1;
                sy_next    = (diff_y < 0) ? -11'sd1 : 11'sd1;
                blk_x_next = block_x_pos;
                blk_y_next = block_y_pos;
                state_next = DRAW;
            end
        end else begin
            plot_en = 1'b1;
            if (cur_x_reg == end_x_reg && cur_y_reg == end_y_reg) begin
                state_next       = IDLE;
                prev_x_next      = end_x_reg[9:0];
                prev_y_next      = end_y_reg[9:0];
                stroke_done_next = 1'b1;
                if (!pen) begin
                    prev_valid_next = 1'b0;
                end
            end else begin
                if (e2 >= dy12 && e2 <= dx12) begin
                    err_next   = err_reg + dy_reg + dx_reg;
                    cur_x_next = cur_x_reg + sx_reg;
                    cur_y_next = cur_y_reg + sy_reg;
                end else if (e2 >= dy12) begin
                    err_next   = err_reg + dy_reg;
                    cur_x_next = cur_x_reg + sx_reg;
                end else if (e2 <= dx12) begin
                    err_next   = err_reg + dx_reg;
                    cur_y_next = cur_y_reg + sy_reg;
                end
            end
        end
    end

    // Window test and bit address for the point chosen above.
    assign rel_x    = plot_x - $signed({1'b0, plot_bx});
    assign rel_y    = plot_y - $signed({1'b0, plot_by});
    assign in_win   = (rel_x >= 0) && (rel_x < BSIZE_S) && (rel_y >= 0) && (rel_y < BSIZE_S);
    assign plot_idx = 12'(rel_y[5:0]) * 12'(BSIZE) + 12'(rel_x[5:0]);

    // Bitmap update: clear wipes everything, otherwise a plotted point only ever sets a bit.
    always_comb begin
        track_next = track_reg;
        if (clear) begin
            track_next = '0;
        end else if (plot_en && in_win) begin
            track_next[plot_idx] = 1'b1;
        end
    end

    // Per-row occupancy feeding the registered empty flag.
    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_row
            assign row_any[gi] = |track_next[gi*B +: B];
        end
    endgenerate
    assign track_empty_next = ~|row_any;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            track_reg       <= '0;
            state_reg       <= IDLE;
            prev_x_reg      <= '0;
            prev_y_reg      <= '0;
            prev_valid_reg  <= 1'b0;
            cur_x_reg       <= '0;
            cur_y_reg       <= '0;
            end_x_reg       <= '0;
            end_y_reg       <= '0;
            dx_reg          <= '0;
            dy_reg          <= '0;
            err_reg         <= '0;
            sx_reg          <= '0;
            sy_reg          <= '0;
            blk_x_reg       <= '0;
            blk_y_reg       <= '0;
            stroke_done_reg <= 1'b0;
            track_empty_reg <= 1'b1;
        end else begin
            track_reg       <= track_next;
            state_reg       <= state_next;
            prev_x_reg      <= prev_x_next;
            prev_y_reg      <= prev_y_next;
            prev_valid_reg  <= prev_valid_next;
            cur_x_reg       <= cur_x_next;
            cur_y_reg       <= cur_y_next;
            end_x_reg       <= end_x_next;
            end_y_reg       <= end_y_next;
            dx_reg          <= dx_next;
            dy_reg          <= dy_next;
            err_reg         <= err_next;
            sx_reg          <= sx_next;
            sy_reg          <= sy_next;
            blk_x_reg       <= blk_x_next;
            blk_y_reg       <= blk_y_next;
            stroke_done_reg <= stroke_done_next;
            track_empty_reg <= track_empty_next;
        end
    end

    assign track       = track_reg;
    assign busy        = (state_reg == DRAW);
    assign stroke_done = stroke_done_reg;
    assign track_empty = track_empty_reg;

endmodule

// File: tb/tb_mouse_track_recorder.sv
// Bench for mouse_track_recorder: a table of single press/move vectors, hand
// sequences for pen-up, clear and draw_en corners, and a randomized run
// compared against a point-list model of the bitmap.
module tb_mouse_track_recorder;

    localparam int B = 52;
    localparam int NB = B * B;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          draw_en = 1'b0;
    logic          clear = 1'b0;
    logic [9:0]    mouse_x = '0, mouse_y = '0;
    logic          mouse_left = 1'b0;
    logic [9:0]    block_x_pos = '0, block_y_pos = '0;
    logic [NB-1:0] track;
    logic          busy, stroke_done, track_empty;

    mouse_track_recorder dut (
        .clk(clk), .rst(rst), .draw_en(draw_en), .clear(clear),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
        .block_x_pos(block_x_pos), .block_y_pos(block_y_pos),
        .track(track), .busy(busy), .stroke_done(stroke_done), .track_empty(track_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sd_cnt = 0;
    int busy_cnt = 0;
    logic [NB-1:0] model;

    always @(negedge clk) begin
        if (stroke_done) sd_cnt = sd_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    typedef struct {
        string name;
        int bx, by, px, py, mx, my;
        int exp_busy, exp_sd, exp_pop, exp_bit;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_track(input string name);
        int first;
        int ndiff;
        first = -1;
        ndiff = 0;
        for (int i = 0; i < NB; i++) begin
            if (track[i] !== model[i]) begin
                ndiff++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (ndiff != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bits differ, first at %0d got %0b expected %0b (popcount got %0d expected %0d)",
                     name, ndiff, first, track[first], model[first], $countones(track), $countones(model));
        end
    endtask

    task automatic model_plot(input int x, input int y, input int bx, input int by);
        if (x >= bx && x < bx + B && y >= by && y < by + B)
            model[(y - by) * B + (x - bx)] = 1'b1;
    endtask

    // Reference line: the textbook error-accumulating walk from (x0,y0) to (x1,y1).
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int k = 0; k < 4096; k++) begin
            model_plot(x, y, bx, by);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        draw_en = 1'b0;
        mouse_left = 1'b0;
        step();
        step();
        rst = 1'b0;
        sd_cnt = 0;
        busy_cnt = 0;
        model = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy still high after %0d cycles", name, n);
        end
    endtask

    task automatic set_cursor(input int x, input int y);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
    endtask

    int bx, by, pv, prx, pry, exp_sd, exp_busy, x, y, r;

    initial begin
        vecs[0] = '{"point",      100, 60, 103,  62, 103,  62,  0, 1,  1,  107};
        vecs[1] = '{"row0",       100, 60, 100,  60, 151,  60, 52, 2, 52,   51};
        vecs[2] = '{"diag",       100, 60, 100,  60, 151, 111, 52, 2, 52, 2703};
        vecs[3] = '{"clip_row10", 100, 60,  80,  70, 170,  70, 91, 2, 52,  571};
        vecs[4] = '{"diag_rev",   100, 60, 151, 111, 100,  60, 52, 2, 52,    0};
        vecs[5] = '{"shallow",    100, 60, 100,  60, 110,  65, 11, 2, 11,  270};
        vecs[6] = '{"origin",       0,  0,   0,   0,  60,   0, 61, 2, 52,   51};

        do_reset();
        step();
        check_int("reset_track_pop", $countones(track), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_stroke_done", int'(stroke_done), 0);
        check_int("reset_track_empty", int'(track_empty), 1);

        // Table-driven single press/move vectors.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            block_x_pos = 10'(vecs[v].bx);
            block_y_pos = 10'(vecs[v].by);
            draw_en = 1'b1;
            mouse_left = 1'b1;
            set_cursor(vecs[v].px, vecs[v].py);
            step();
            set_cursor(vecs[v].mx, vecs[v].my);
            step();
            wait_idle(vecs[v].name);
            step();
            step();
            mouse_left = 1'b0;
            step();
            model_plot(vecs[v].px, vecs[v].py, vecs[v].bx, vecs[v].by);
            if (vecs[v].px != vecs[v].mx || vecs[v].py != vecs[v].my)
                model_line(vecs[v].px, vecs[v].py, vecs[v].mx, vecs[v].my, vecs[v].bx, vecs[v].by);
            check_int({vecs[v].name, "_busy_cycles"}, busy_cnt, vecs[v].exp_busy);
            check_int({vecs[v].name, "_stroke_done"}, sd_cnt, vecs[v].exp_sd);
            check_int({vecs[v].name, "_popcount"}, $countones(track), vecs[v].exp_pop);
            check_int({vecs[v].name, "_key_bit"}, int'(track[vecs[v].exp_bit]), 1);
            check_int({vecs[v].name, "_empty"}, int'(track_empty), 0);
            check_track({vecs[v].name, "_bitmap"});
            $display("vector %s: busy=%0d strokes=%0d pop=%0d", vecs[v].name, busy_cnt, sd_cnt, $countones(track));
        end

        // Pen-up between two presses: no connecting segment.
        do_reset();
        block_x_pos = 10'd100;
        block_y_pos = 10'd60;
        draw_en = 1'b1;
        mouse_left = 1'b1;
        set_cursor(100, 60);
        step();
        mouse_left = 1'b0;
        step();
        set_cursor(140, 60);
        mouse_left = 1'b1;
        step();
        step();
        step();
        mouse_left = 1'b0;
        step();
        check_int("penup_pop", $countones(track), 2);
        check_int("penup_bit0", int'(track[0]), 1);
        check_int("penup_bit40", int'(track[40]), 1);
        check_int("penup_busy", busy_cnt, 0);
        check_int("penup_strokes", sd_cnt, 2);
        $display("sequence penup: pop=%0d strokes=%0d", $countones(track), sd_cnt);

        // Clear on the 10th DRAW cycle aborts the segment silently.
        do_reset();
        block_x_pos = 10'd100;
        block_y_pos = 10'd60;
        draw_en = 1'b1;
        mouse_left = 1'b1;
        set_cursor(100, 60);
        step();
        set_cursor(151, 111);
        step();
        for (int k = 0; k < 9; k++) step();
        check_int("clear_busy_before", int'(busy), 1);
        clear = 1'b1;
        mouse_left = 1'b0;
        set_cursor(101, 61);
        step();
        clear = 1'b0;
        check_int("clear_track_pop", $countones(track), 0);
        check_int("clear_busy", int'(busy), 0);
        check_int("clear_empty", int'(track_empty), 1);
        check_int("clear_no_stroke", int'(stroke_done), 0);
        step();
        step();
        check_int("clear_strokes", sd_cnt, 1);
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        step();
        step();
        check_int("clear_after_pop", $countones(track), 1);
        check_int("clear_after_bit53", int'(track[53]), 1);
        check_int("clear_after_strokes", sd_cnt, 2);
        $display("sequence clear: pop=%0d strokes=%0d", $countones(track), sd_cnt);

        // draw_en gates the pen; dropping it mid-segment does not abort but ends the stroke.
        do_reset();
        block_x_pos = 10'd100;
        block_y_pos = 10'd60;
        draw_en = 1'b0;
        mouse_left = 1'b1;
        set_cursor(110, 70);
        step();
        step();
        check_int("den_off_pop", $countones(track), 0);
        check_int("den_off_strokes", sd_cnt, 0);
        draw_en = 1'b1;
        step();
        set_cursor(120, 70);
        step();
        draw_en = 1'b0;
        wait_idle("den_drop");
        step();
        check_int("den_drop_pop", $countones(track), 11);
        check_int("den_drop_busy", busy_cnt, 11);
        check_int("den_drop_bit530", int'(track[530]), 1);
        draw_en = 1'b1;
        set_cursor(130, 70);
        step();
        step();
        check_int("den_restart_pop", $countones(track), 12);
        check_int("den_restart_busy", busy_cnt, 11);
        check_int("den_restart_strokes", sd_cnt, 3);
        $display("sequence draw_en: pop=%0d strokes=%0d", $countones(track), sd_cnt);

        // Randomized operations against the point-list model.
        do_reset();
        bx = $urandom_range(0, 500);
        by = $urandom_range(0, 400);
        pv = 0;
        prx = 0;
        pry = 0;
        exp_sd = 0;
        draw_en = 1'b1;
        for (int op = 0; op < 60; op++) begin
            r = $urandom_range(0, 9);
            block_x_pos = 10'(bx);
            block_y_pos = 10'(by);
            busy_cnt = 0;
            exp_busy = 0;
            if (r == 0) begin
                mouse_left = 1'b0;
                step();
                pv = 0;
            end else if (r == 1) begin
                mouse_left = 1'b0;
                clear = 1'b1;
                step();
                clear = 1'b0;
                model = '0;
                pv = 0;
            end else if (r == 2) begin
                bx = $urandom_range(0, 500);
                by = $urandom_range(0, 400);
            end else begin
                x = bx - 15 + $urandom_range(0, 81);
                y = by - 15 + $urandom_range(0, 81);
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                set_cursor(x, y);
                mouse_left = 1'b1;
                step();
                if (pv == 0) begin
                    model_plot(x, y, bx, by);
                    exp_sd++;
                end else if (x != prx || y != pry) begin
                    model_line(prx, pry, x, y, bx, by);
                    exp_busy = (((x > prx) ? x - prx : prx - x) > ((y > pry) ? y - pry : pry - y))
                             ? ((x > prx) ? x - prx : prx - x) + 1
                             : ((y > pry) ? y - pry : pry - y) + 1;
                    exp_sd++;
                end
                pv = 1;
                prx = x;
                pry = y;
                wait_idle("rand_wait");
            end
            step();
            check_int("rand_busy_cycles", busy_cnt, exp_busy);
            check_track("rand_bitmap");
            check_int("rand_empty", int'(track_empty), (model == '0) ? 1 : 0);
            $display("random op %0d: kind=%0d block=(%0d,%0d) busy=%0d pop=%0d", op, r, bx, by, busy_cnt, $countones(track));
        end
        check_int("rand_strokes", sd_cnt, exp_sd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
